// File: rtl/i2c_master_regs_pkg.sv
// Register addresses and bit positions shared by the I2C master register file
// and anything that needs to decode its bus traffic.
package i2c_master_regs_pkg;

  // Register map
  localparam logic [2:0] I2C_PRER = 3'd0;
  localparam logic [2:0] I2C_CTR  = 3'd1;
  localparam logic [2:0] I2C_TXR  = 3'd2;
  localparam logic [2:0] I2C_CR   = 3'd3;
  localparam logic [2:0] I2C_RXR  = 3'd4;
  localparam logic [2:0] I2C_SR   = 3'd5;

  // CTR bits
  localparam int CTR_EN  = 7;
  localparam int CTR_IEN = 6;

  // CR bits
  localparam int CR_STA   = 7;
  localparam int CR_STO   = 6;
  localparam int CR_RD    = 5;
  localparam int CR_WR    = 4;
  localparam int CR_ACK   = 3;
  localparam int CR_RSVD  = 2;
  localparam int CR_ALACK = 1;
  localparam int CR_IACK  = 0;

  // SR bits (4:2 read as zero)
  localparam int SR_RXACK = 7;
  localparam int SR_BUSY  = 6;
  localparam int SR_AL    = 5;
  localparam int SR_TIP   = 1;
  localparam int SR_IF    = 0;

endpackage

// File: rtl/i2c_master_regs.sv
// Bus-facing register file of the I2C master: prescale, control, transmit and
// command registers, status flags and the interrupt request.
module i2c_master_regs
  import i2c_master_regs_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 3
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [AWIDTH-1:0] Addr,
  input  logic [DWIDTH-1:0] DataIn,
  output logic [DWIDTH-1:0] DataOut,
  input  logic              Wr,
  output logic              Int,
  output logic              Start,
  output logic              Stop,
  output logic              Read,
  output logic              Write,
  output logic              Tx_ack,
  output logic [7:0]        Tx_data,
  output logic [7:0]        Prescale,
  output logic              I2C_en,
  input  logic              Rx_ack,
  input  logic [7:0]        Rx_data,
  input  logic              I2C_busy,
  input  logic              I2C_done,
  input  logic              I2C_al
);

  logic [7:0] prer;
  logic [7:0] ctr;
  logic [7:0] txr;
  logic [7:0] cr;
  logic       rxack;
  logic       busy;
  logic       al;
  logic       tip;
  logic       irq_flag;
  logic       int_q;
  logic [7:0] sr;
  logic       cr_we;
  logic       cmd_end;

  assign cr_we   = Wr && (Addr == I2C_CR);
  // A completed byte and a lost arbitration both terminate the current command.
  assign cmd_end = I2C_done | I2C_al;

  // Plain read/write configuration registers.
  always_ff @(posedge Clk) begin
    // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
    if (Rst) begin
      prer <= '0;
      ctr  <= '0;
      txr  <= '0;
    end else if (Wr) begin
      case (Addr)
        I2C_PRER: prer <= DataIn;
        I2C_CTR:  ctr  <= DataIn;
        I2C_TXR:  txr  <= DataIn;
        default:  ;
      endcase
    end
  end

  // Command register: acknowledge bits are one-shot, command bits self-clear
  // when the controller reports the end of the command (which wins over a write).
  always_ff @(posedge Clk) begin
    if (Rst) begin
      cr <= '0;
    end else begin
      if (cr_we) begin
        cr          <= DataIn;
        cr[CR_RSVD] <= 1'b0;
      end else begin
        cr[CR_ALACK] <= 1'b0;
        cr[CR_IACK]  <= 1'b0;
      end
      if (cmd_end) begin
        cr[CR_STA] <= 1'b0;
        cr[CR_STO] <= 1'b0;
        cr[CR_RD]  <= 1'b0;
        cr[CR_WR]  <= 1'b0;
      end
    end
  end

  // Status flags; a flag being set takes precedence over its acknowledge.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      rxack    <= 1'b0;
      busy     <= 1'b0;
      al       <= 1'b0;
      tip      <= 1'b0;
      irq_flag <= 1'b0;
      int_q    <= 1'b0;
    end else begin
      rxack <= Rx_ack;
      busy  <= I2C_busy;
      int_q <= irq_flag & ctr[CTR_IEN];

      if (I2C_al)                          al <= 1'b1;
      else if (cr_we && DataIn[CR_ALACK])  al <= 1'b0;

      if (cmd_end)                                     tip <= 1'b0;
      else if (cr_we && (DataIn[CR_RD] | DataIn[CR_WR])) tip <= 1'b1;

      if (cmd_end)                         irq_flag <= 1'b1;
      else if (cr_we && DataIn[CR_IACK])   irq_flag <= 1'b0;
    end
  end

  // Assemble the status byte.
  always_comb begin
    // NOTE: assigning a default first guarantees no latch for unlisted bits/cases.
    sr           = '0;
    sr[SR_RXACK] = rxack;
    sr[SR_BUSY]  = busy;
    sr[SR_AL]    = al;
    sr[SR_TIP]   = tip;
    sr[SR_IF]    = irq_flag;
  end

  // Zero-latency read multiplexer; unmapped addresses read as zero.
  always_comb begin
    DataOut = '0;
    case (Addr)
      I2C_PRER: DataOut = prer;
      I2C_CTR:  DataOut = ctr;
      I2C_TXR:  DataOut = txr;
      I2C_CR:   DataOut = cr;
      I2C_RXR:  DataOut = Rx_data;
      I2C_SR:   DataOut = sr;
      default:  DataOut = '0;
    endcase
  end

  assign Int      = int_q;
  assign Start    = cr[CR_STA];
  assign Stop     = cr[CR_STO];
  assign Read     = cr[CR_RD];
  assign Write    = cr[CR_WR];
  assign Tx_ack   = cr[CR_ACK];
  assign Tx_data  = txr;
  assign Prescale = prer;
  assign I2C_en   = ctr[CTR_EN];

endmodule

// File: tb/tb_i2c_master_regs.sv
// Self-checking bench for i2c_master_regs: directed vector table, hand-written
// corner sequences and randomized traffic against a register-level model.
module tb_i2c_master_regs;

  typedef struct {
    logic       rst;
    logic       wr;
    logic [2:0] addr;
    logic [7:0] din;
    logic       done;
    logic       al;
    logic       rx_ack;
    logic [7:0] rx_data;
    logic       busy;
  } stim_t;

  typedef struct {
    stim_t      s;
    logic [2:0] rd;
    logic [7:0] exp_data;
    logic       exp_int;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst, wr, done, al, rx_ack, busy;
  logic [2:0] addr;
  logic [7:0] din, rx_data, dout, tx_data, prescale;
  logic       irq, start, stop, rd_cmd, wr_cmd, tx_ack, en;

  int vectors     = 0;
  int miscompares = 0;

  // Model state: the visible contents of each register.
  logic [7:0] m_prer, m_ctr, m_txr, m_cr;
  logic       m_rxack, m_busy, m_al, m_tip, m_if, m_int;

  always #10 clk = ~clk;

  i2c_master_regs #(.DWIDTH(8), .AWIDTH(3)) dut (
    .Clk(clk), .Rst(rst), .Addr(addr), .DataIn(din), .DataOut(dout), .Wr(wr),
    .Int(irq), .Start(start), .Stop(stop), .Read(rd_cmd), .Write(wr_cmd),
    .Tx_ack(tx_ack), .Tx_data(tx_data), .Prescale(prescale), .I2C_en(en),
    .Rx_ack(rx_ack), .Rx_data(rx_data), .I2C_busy(busy), .I2C_done(done),
    .I2C_al(al)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{rst: 1'b0, wr: 1'b0, addr: 3'd0, din: 8'h00, done: 1'b0, al: 1'b0,
          rx_ack: 1'b0, rx_data: 8'h00, busy: 1'b0};
    return s;
  endfunction

  function automatic stim_t wr_stim(input logic [2:0] a, input logic [7:0] d);
    stim_t s;
    s = idle();
    s.wr = 1'b1; s.addr = a; s.din = d;
    return s;
  endfunction

  function automatic vec_t v(input stim_t s, input logic [2:0] r,
                             input logic [7:0] e, input logic ei);
    vec_t x;
    x.s = s; x.rd = r; x.exp_data = e; x.exp_int = ei;
    return x;
  endfunction

  // One clock of the reference: what each register holds after an edge,
  // stated as masks and flag rules rather than per-bit logic.
  task automatic model_step(input stim_t s);
    logic ends, cr_write;
    logic [7:0] ncr;
    if (s.rst) begin
      {m_prer, m_ctr, m_txr, m_cr} = '0;
      {m_rxack, m_busy, m_al, m_tip, m_if, m_int} = '0;
      return;
    end
    ends     = s.done | s.al;
    cr_write = s.wr && (s.addr == 3'd3);
    m_int    = m_if & m_ctr[6];
    if (s.wr && s.addr == 3'd0) m_prer = s.din;
    if (s.wr && s.addr == 3'd1) m_ctr  = s.din;
    if (s.wr && s.addr == 3'd2) m_txr  = s.din;
    ncr = cr_write ? (s.din & 8'hFB) : (m_cr & 8'hF8);
    if (ends) ncr = ncr & 8'h0F;
    m_cr = ncr;
    if (ends) m_tip = 1'b0;
    else if (cr_write && (s.din & 8'h30) != 8'h00) m_tip = 1'b1;
    if (ends) m_if = 1'b1;
    else if (cr_write && s.din[0]) m_if = 1'b0;
    if (s.al) m_al = 1'b1;
    else if (cr_write && s.din[1]) m_al = 1'b0;
    m_rxack = s.rx_ack;
    m_busy  = s.busy;
  endtask

  function automatic logic [7:0] m_read(input logic [2:0] a);
    case (a)
      3'd0:    return m_prer;
      3'd1:    return m_ctr;
      3'd2:    return m_txr;
      3'd3:    return m_cr;
      3'd4:    return rx_data;
      3'd5:    return {m_rxack, m_busy, m_al, 3'b000, m_tip, m_if};
      default: return 8'h00;
    endcase
  endfunction

  task automatic cycle(input stim_t s);
    rst = s.rst; wr = s.wr; addr = s.addr; din = s.din; done = s.done;
    al = s.al; rx_ack = s.rx_ack; rx_data = s.rx_data; busy = s.busy;
    @(posedge clk);
    model_step(s);
    #1;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".cmd"}, {start, stop, rd_cmd, wr_cmd, tx_ack, 3'b000}, m_cr & 8'hF8);
    check({tag, ".tx_data"}, tx_data, m_txr);
    check({tag, ".prescale"}, prescale, m_prer);
    check({tag, ".en"}, {7'd0, en}, {7'd0, m_ctr[7]});
    check({tag, ".int"}, {7'd0, irq}, {7'd0, m_int});
    for (int a = 0; a < 8; a++) begin
      addr = 3'(a);
      #1;
      check($sformatf("%s.rd%0d", tag, a), dout, m_read(3'(a)));
    end
  endtask

  vec_t  tbl[$];
  stim_t s;

  initial begin
    s = idle();
    s.rst = 1'b1;
    cycle(s);
    cycle(s);
    addr = 3'd0;
    #1;
    check("reset.dout0", dout, 8'h00);
    check("reset.int", {7'd0, irq}, 8'h00);
    check_all("reset");

    // Bus read/write
    foreach (tbl[i]) ;
    tbl.push_back(v(wr_stim(3'd2, 8'hAA), 3'd2, 8'hAA, 1'b0));
    tbl.push_back(v(wr_stim(3'd1, 8'hAA), 3'd1, 8'hAA, 1'b0));
    tbl.push_back(v(wr_stim(3'd0, 8'hAA), 3'd0, 8'hAA, 1'b0));
    tbl.push_back(v(wr_stim(3'd2, 8'h55), 3'd2, 8'h55, 1'b0));
    tbl.push_back(v(wr_stim(3'd1, 8'h55), 3'd1, 8'h55, 1'b0));
    tbl.push_back(v(wr_stim(3'd0, 8'h55), 3'd0, 8'h55, 1'b0));
    tbl.push_back(v(wr_stim(3'd2, 8'h00), 3'd2, 8'h00, 1'b0));
    tbl.push_back(v(wr_stim(3'd1, 8'h00), 3'd1, 8'h00, 1'b0));
    tbl.push_back(v(wr_stim(3'd0, 8'h00), 3'd0, 8'h00, 1'b0));
    // Transfer done and TIP
    tbl.push_back(v(wr_stim(3'd3, 8'h10), 3'd5, 8'h02, 1'b0));
    s = idle(); s.done = 1'b1; s.rx_ack = 1'b1;
    tbl.push_back(v(s, 3'd5, 8'h81, 1'b0));
    s = idle(); s.rx_ack = 1'b1;
    tbl.push_back(v(s, 3'd3, 8'h00, 1'b0));
    tbl.push_back(v(wr_stim(3'd3, 8'h01), 3'd5, 8'h00, 1'b0));
    tbl.push_back(v(idle(), 3'd3, 8'h00, 1'b0));
    // Arbitration lost
    tbl.push_back(v(wr_stim(3'd3, 8'h80), 3'd3, 8'h80, 1'b0));
    s = idle(); s.al = 1'b1;
    tbl.push_back(v(s, 3'd3, 8'h00, 1'b0));
    tbl.push_back(v(idle(), 3'd5, 8'h21, 1'b0));
    tbl.push_back(v(wr_stim(3'd3, 8'h02), 3'd5, 8'h01, 1'b0));
    tbl.push_back(v(idle(), 3'd3, 8'h00, 1'b0));
    tbl.push_back(v(wr_stim(3'd3, 8'h01), 3'd5, 8'h00, 1'b0));
    // Interrupt sources with IEN=1
    tbl.push_back(v(wr_stim(3'd1, 8'hC0), 3'd1, 8'hC0, 1'b0));
    s = idle(); s.done = 1'b1;
    tbl.push_back(v(s, 3'd5, 8'h01, 1'b0));
    tbl.push_back(v(idle(), 3'd5, 8'h01, 1'b1));
    tbl.push_back(v(wr_stim(3'd3, 8'h01), 3'd5, 8'h00, 1'b1));
    tbl.push_back(v(idle(), 3'd5, 8'h00, 1'b0));
    s = idle(); s.al = 1'b1;
    tbl.push_back(v(s, 3'd5, 8'h21, 1'b0));
    tbl.push_back(v(idle(), 3'd5, 8'h21, 1'b1));
    tbl.push_back(v(wr_stim(3'd3, 8'h03), 3'd5, 8'h00, 1'b1));
    tbl.push_back(v(idle(), 3'd3, 8'h00, 1'b0));
    // IEN=0: flag without interrupt
    tbl.push_back(v(wr_stim(3'd1, 8'h80), 3'd1, 8'h80, 1'b0));
    s = idle(); s.done = 1'b1;
    tbl.push_back(v(s, 3'd5, 8'h01, 1'b0));
    tbl.push_back(v(idle(), 3'd5, 8'h01, 1'b0));
    tbl.push_back(v(idle(), 3'd5, 8'h01, 1'b0));
    tbl.push_back(v(wr_stim(3'd3, 8'h01), 3'd5, 8'h00, 1'b0));
    // Receive path and busy
    s = idle(); s.rx_data = 8'hA5;
    tbl.push_back(v(s, 3'd4, 8'hA5, 1'b0));
    tbl.push_back(v(s, 3'd5, 8'h00, 1'b0));
    s = idle(); s.busy = 1'b1;
    tbl.push_back(v(s, 3'd5, 8'h40, 1'b0));
    tbl.push_back(v(idle(), 3'd5, 8'h00, 1'b0));
    // Same-cycle priorities
    s = wr_stim(3'd3, 8'h30); s.done = 1'b1;
    tbl.push_back(v(s, 3'd3, 8'h00, 1'b0));
    tbl.push_back(v(idle(), 3'd5, 8'h01, 1'b0));
    s = wr_stim(3'd3, 8'h01); s.done = 1'b1;
    tbl.push_back(v(s, 3'd5, 8'h01, 1'b0));
    s = wr_stim(3'd3, 8'h03); s.al = 1'b1;
    tbl.push_back(v(s, 3'd5, 8'h21, 1'b0));
    tbl.push_back(v(wr_stim(3'd3, 8'h03), 3'd5, 8'h00, 1'b0));
    // Unmapped addresses and ACK retention
    tbl.push_back(v(wr_stim(3'd6, 8'hFF), 3'd6, 8'h00, 1'b0));
    tbl.push_back(v(idle(), 3'd7, 8'h00, 1'b0));
    tbl.push_back(v(wr_stim(3'd3, 8'h08), 3'd3, 8'h08, 1'b0));
    s = idle(); s.done = 1'b1;
    tbl.push_back(v(s, 3'd3, 8'h08, 1'b0));

    foreach (tbl[i]) begin
      cycle(tbl[i].s);
      addr = tbl[i].rd;
      #1;
      check($sformatf("vec%0d.data", i), dout, tbl[i].exp_data);
      check($sformatf("vec%0d.int", i), {7'd0, irq}, {7'd0, tbl[i].exp_int});
      check_all($sformatf("vec%0d", i));
    end

    // Int must follow each event source within 3 cycles when IEN=1.
    for (int src = 0; src < 2; src++) begin
      bit seen;
      cycle(wr_stim(3'd1, 8'hC0));
      cycle(wr_stim(3'd3, 8'h03));
      cycle(idle());
      s = idle();
      if (src == 0) s.done = 1'b1; else s.al = 1'b1;
      cycle(s);
      seen = irq;
      for (int n = 0; n < 2 && !seen; n++) begin
        cycle(idle());
        seen = irq;
      end
      check($sformatf("int_within3.src%0d", src), {7'd0, seen}, 8'h01);
      check_all($sformatf("int_within3.src%0d", src));
    end

    // Reset while a command is pending with flags and Int raised.
    cycle(wr_stim(3'd0, 8'h3C));
    cycle(wr_stim(3'd2, 8'h96));
    cycle(wr_stim(3'd3, 8'h90));
    s = idle(); s.al = 1'b1;
    cycle(s);
    cycle(idle());
    cycle(wr_stim(3'd3, 8'hA8));
    check_all("pre_reset");
    s = idle(); s.rst = 1'b1;
    cycle(s);
    check("rst_mid.cmd", {start, stop, rd_cmd, wr_cmd, tx_ack, 3'b000}, 8'h00);
    check("rst_mid.int", {7'd0, irq}, 8'h00);
    check("rst_mid.tx_data", tx_data, 8'h00);
    check("rst_mid.prescale", prescale, 8'h00);
    check("rst_mid.en", {7'd0, en}, 8'h00);
    for (int a = 0; a < 6; a++) begin
      addr = 3'(a);
      #1;
      check($sformatf("rst_mid.rd%0d", a), dout, 8'h00);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      s.rst     = ($urandom_range(0, 63) == 0);
      s.wr      = $urandom_range(0, 1) == 1;
      s.addr    = 3'($urandom_range(0, 7));
      s.din     = 8'($urandom);
      s.done    = ($urandom_range(0, 7) == 0);
      s.al      = ($urandom_range(0, 15) == 0);
      s.rx_ack  = $urandom_range(0, 1) == 1;
      s.rx_data = 8'($urandom);
      s.busy    = $urandom_range(0, 1) == 1;
      cycle(s);
      check_all($sformatf("rand%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
